// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits LSB first, even parity, stop bit.
// Bit timing is derived from OVERSAMPLE sample_ENABLE ticks per bit.
module uart_transmitter #(
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] Tx_DATA,
   input  logic       Tx_EN,
   input  logic       Tx_WR,
   input  logic       sample_ENABLE,
   output logic       TxD,
   output logic       Tx_BUSY
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

   state_t     state, state_next;
   logic [3:0] tick_cnt, tick_next;
   logic [2:0] bit_idx, idx_next;
   logic [7:0] shift_reg, shift_next;
   logic       parity;
   logic       txd_next, busy_next;
   logic       accept, bit_end;

   assign accept  = (state == IDLE) && Tx_EN && Tx_WR;
   assign bit_end = sample_ENABLE && (tick_cnt == LAST_TICK);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         parity    <= 1'b0;
         TxD       <= 1'b1;
         Tx_BUSY   <= 1'b0;
      end else begin
         state     <= state_next;
         tick_cnt  <= tick_next;
         bit_idx   <= idx_next;
         shift_reg <= shift_next;
         TxD       <= txd_next;
         Tx_BUSY   <= busy_next;
         if (accept)
            parity <= ^Tx_DATA;
      end
   end

   always_comb begin
      state_next = state;
      tick_next  = tick_cnt;
      idx_next   = bit_idx;
      shift_next = shift_reg;
      if (state == IDLE) begin
         tick_next = '0;
         idx_next  = '0;
         if (accept) begin
            state_next = START;
            shift_next = Tx_DATA;
         end
      end else if (bit_end) begin
         tick_next = '0;
         case (state)
            START:   state_next = DATA;
            DATA: begin
               shift_next = shift_reg >> 1;
               idx_next   = bit_idx + 3'd1;
               if (bit_idx == 3'd7)
                  state_next = PARITY;
            end
            PARITY:  state_next = STOP;
            STOP:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end else if (sample_ENABLE) begin
         tick_next = tick_cnt + 4'd1;
      end
   end

   // Outputs are decoded from the next state so TxD/Tx_BUSY can be registered
   // without adding a cycle of latency.
   always_comb begin
      txd_next  = 1'b1;
      busy_next = 1'b1;
      case (state_next)
         IDLE:    busy_next = 1'b0;
         START:   txd_next  = 1'b0;
         DATA:    txd_next  = shift_next[0];
         PARITY:  txd_next  = parity;
         STOP:    txd_next  = 1'b1;
         default: busy_next = 1'b0;
      endcase
   end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter OVERSAMPLE, default 16: number of sample_ENABLE pulses per serial bit.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Tx_DATA  input  8  byte to transmit; sampled only on an accepted write.
REQ-005 Tx_EN  input  1  transmitter enable; writes are accepted only while high.
REQ-006 Tx_WR  input  1  write strobe; one-cycle pulse requests transmission of Tx_DATA.
REQ-007 sample_ENABLE  input  1  one-clk-wide oversampling tick from the baud rate generator (OVERSAMPLE ticks per bit).
REQ-008 TxD  output  1  serial line; idle/mark level 1.
REQ-009 Tx_BUSY  output  1  high while a frame is in progress; a new write is not accepted while high.

Function
REQ-010 Frame format SHALL be: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit (XOR of the 8 data bits), 1 stop bit (1); 11 bits total.
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-012 A write SHALL be accepted when state=IDLE, Tx_EN=1 and Tx_WR=1 on the same rising edge; Tx_DATA is latched into an internal shift register and parity is computed from the latched value.
REQ-013 On acceptance the FSM SHALL enter START; TxD=0 and Tx_BUSY=1 starting the cycle after the accepting edge.
REQ-014 A 4-bit tick counter SHALL be cleared on acceptance and on every bit transition, and SHALL increment only on cycles with sample_ENABLE=1.
REQ-015 A bit SHALL end on the clock edge where sample_ENABLE=1 and the tick counter equals OVERSAMPLE-1; the next bit drives TxD starting the cycle after that edge.
REQ-016 Each bit SHALL therefore last exactly OVERSAMPLE sample_ENABLE pulses; the start bit is measured from the first tick after acceptance.
REQ-017 DATA SHALL transmit bits 0..7 in order, tracked by a 3-bit index; DATA exits to PARITY after bit 7.
REQ-018 PARITY SHALL drive the even-parity bit for one bit time, then go to STOP.
REQ-019 STOP SHALL drive TxD=1 for one bit time, then go to IDLE; Tx_BUSY falls in the cycle after the final tick edge.
REQ-020 Tx_WR while Tx_BUSY=1 (including on the STOP-ending edge) SHALL be ignored; no queuing.
REQ-021 Tx_WR while Tx_EN=0 SHALL be ignored; TxD stays 1.
REQ-022 Deasserting Tx_EN mid-frame SHALL NOT abort the frame; it completes normally.
REQ-023 Changes of Tx_DATA after acceptance SHALL NOT affect the frame in flight.
REQ-024 TxD and Tx_BUSY SHALL be driven from registers (glitch-free).

Reset
REQ-025 While reset=1: state=IDLE, TxD=1, Tx_BUSY=0, tick counter=0, bit index=0, shift register=0.
REQ-026 Reset asserted mid-frame SHALL immediately (asynchronously) force TxD=1 and Tx_BUSY=0; the partial frame is abandoned.
REQ-027 After reset deasserts, the first accepted write SHALL produce a complete, correct frame.

Verification
REQ-028 sample_ENABLE every 4th clk, Tx_EN=1, write 8'hA5 -> TxD = 0,1,0,1,0,0,1,0,1,0(parity),1; each bit 64 clk; Tx_BUSY high 176 ticks (704 clk).
REQ-029 Write 8'h01 -> parity bit 1; write 8'h00 -> parity bit 0, data bits all 0.
REQ-030 Second Tx_WR pulsed mid-frame with 8'hFF -> ignored; the first frame is unchanged; no second frame follows.
REQ-031 Tx_EN=0, Tx_WR pulsed -> TxD stays 1, Tx_BUSY stays 0; Tx_EN dropped during DATA -> frame completes.
REQ-032 Reset pulsed during DATA bit 3 -> TxD=1 and Tx_BUSY=0 immediately; a subsequent write of 8'h3C transmits correctly.
REQ-033 Tx_WR asserted the cycle Tx_BUSY falls -> accepted; back-to-back frames have no gap beyond one clk plus tick alignment.
